// File: rtl/uart_bus_bridge.sv
// UART 8N1 command bridge: receives 'W'/'R' frames, issues one-cycle bus strobes,
// and returns read data as four UART bytes, MSB first.
module uart_bus_bridge #(
  parameter int unsigned BAUD_DIV = 5208
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        uart_rx,
  output logic        uart_tx,
  output logic        rd,
  output logic        wr,
  output logic [31:0] addr,
  output logic [31:0] wdata,
  input  logic [31:0] rdata,
  output logic        busy,
  output logic        frame_err
);
  localparam logic [15:0] LP_FULL  = 16'(BAUD_DIV - 1);
  localparam logic [15:0] LP_HALF  = 16'(BAUD_DIV / 2 - 1);
  localparam logic [7:0]  LP_OP_WR = 8'h57;
  localparam logic [7:0]  LP_OP_RD = 8'h52;

  typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_t;
  typedef enum logic [2:0] {C_IDLE, C_ADDR, C_DATA, C_BUS_WR, C_BUS_RD, C_SEND} cmd_state_t;

  logic        r_rx_meta, r_rx_sync, r_rx_prev;
  rx_state_t   r_rx_state, w_rx_next;
  logic [15:0] r_rx_cnt;
  logic [2:0]  r_rx_bit;
  logic [7:0]  r_rx_shift;
  logic        r_rx_valid, r_frame_err;
  logic        w_rx_half, w_rx_tick;

  cmd_state_t  r_cmd_state, w_cmd_next;
  logic [1:0]  r_cnt;
  logic        r_op_wr;
  logic [31:0] r_addr, r_wdata, r_rd_shift;
  logic        r_rd, r_wr, r_busy;

  logic        r_tx, r_tx_active;
  logic [15:0] r_tx_cnt;
  logic [3:0]  r_tx_bit;
  logic [8:0]  r_tx_shift;
  logic        w_tx_tick, w_tx_done, w_tx_load;

  // Two-flop synchronizer plus one delay stage for falling-edge detection.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_rx_meta <= 1'b1;
      r_rx_sync <= 1'b1;
      r_rx_prev <= 1'b1;
    end else begin
      r_rx_meta <= uart_rx;
      r_rx_sync <= r_rx_meta;
      r_rx_prev <= r_rx_sync;
    end
  end

  assign w_rx_half = (r_rx_cnt == LP_HALF);
  assign w_rx_tick = (r_rx_cnt == LP_FULL);

  always_comb begin
    w_rx_next = r_rx_state;
    case (r_rx_state)
      RX_IDLE:  if (r_rx_prev && !r_rx_sync) w_rx_next = RX_START; else w_rx_next = RX_IDLE;
      RX_START: if (w_rx_half) w_rx_next = r_rx_sync ? RX_IDLE : RX_DATA; else w_rx_next = RX_START;
      RX_DATA:  if (w_rx_tick && (r_rx_bit == 3'd7)) w_rx_next = RX_STOP; else w_rx_next = RX_DATA;
      RX_STOP:  if (w_rx_tick) w_rx_next = RX_IDLE; else w_rx_next = RX_STOP;
      default:  w_rx_next = RX_IDLE;
    endcase
  end

  // Bit timer restarts on every state change so data samples land one bit apart from mid-start.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_rx_state  <= RX_IDLE;
      r_rx_cnt    <= 16'd0;
      r_rx_bit    <= 3'd0;
      r_rx_shift  <= 8'd0;
      r_rx_valid  <= 1'b0;
      r_frame_err <= 1'b0;
    end else begin
      r_rx_state <= w_rx_next;
      if ((r_rx_state == RX_IDLE) || (w_rx_next != r_rx_state) || w_rx_tick) r_rx_cnt <= 16'd0;
      else r_rx_cnt <= r_rx_cnt + 16'd1;
      if ((r_rx_state == RX_DATA) && w_rx_tick) begin
        r_rx_shift <= {r_rx_sync, r_rx_shift[7:1]};
        r_rx_bit   <= r_rx_bit + 3'd1;
      end
      r_rx_valid  <= (r_rx_state == RX_STOP) && w_rx_tick && r_rx_sync;
      r_frame_err <= (r_rx_state == RX_STOP) && w_rx_tick && !r_rx_sync;
    end
  end

  assign w_tx_tick = (r_tx_cnt == LP_FULL);
  assign w_tx_done = r_tx_active && w_tx_tick && (r_tx_bit == 4'd9);
  // Reload in the same cycle the previous stop bit ends so response bytes are back-to-back.
  assign w_tx_load = (r_cmd_state == C_SEND) && (!r_tx_active || (w_tx_done && (r_cnt != 2'd3)));

  always_comb begin
    w_cmd_next = r_cmd_state;
    case (r_cmd_state)
      C_IDLE: begin
        if (r_rx_valid && ((r_rx_shift == LP_OP_WR) || (r_rx_shift == LP_OP_RD))) w_cmd_next = C_ADDR;
        else w_cmd_next = C_IDLE;
      end
      C_ADDR: begin
        if (r_frame_err) w_cmd_next = C_IDLE;
        else if (r_rx_valid && (r_cnt == 2'd3)) w_cmd_next = r_op_wr ? C_DATA : C_BUS_RD;
        else w_cmd_next = C_ADDR;
      end
      C_DATA: begin
        if (r_frame_err) w_cmd_next = C_IDLE;
        else if (r_rx_valid && (r_cnt == 2'd3)) w_cmd_next = C_BUS_WR;
        else w_cmd_next = C_DATA;
      end
      C_BUS_WR: w_cmd_next = C_IDLE;
      C_BUS_RD: w_cmd_next = C_SEND;
      C_SEND:   if (w_tx_done && (r_cnt == 2'd3)) w_cmd_next = C_IDLE; else w_cmd_next = C_SEND;
      default:  w_cmd_next = C_IDLE;
    endcase
  end

  // Strobes and busy are registered from the next state so they align with BUS_* / non-IDLE.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_cmd_state <= C_IDLE;
      r_cnt       <= 2'd0;
      r_op_wr     <= 1'b0;
      r_addr      <= 32'd0;
      r_wdata     <= 32'd0;
      r_rd_shift  <= 32'd0;
      r_rd        <= 1'b0;
      r_wr        <= 1'b0;
      r_busy      <= 1'b0;
    end else begin
      r_cmd_state <= w_cmd_next;
      r_rd        <= (w_cmd_next == C_BUS_RD);
      r_wr        <= (w_cmd_next == C_BUS_WR);
      r_busy      <= (w_cmd_next != C_IDLE);
      case (r_cmd_state)
        C_IDLE: begin
          r_cnt <= 2'd0;
          if (r_rx_valid) r_op_wr <= (r_rx_shift == LP_OP_WR);
        end
        C_ADDR: if (r_rx_valid) begin
          r_addr <= {r_addr[23:0], r_rx_shift};
          r_cnt  <= r_cnt + 2'd1;
        end
        C_DATA: if (r_rx_valid) begin
          r_wdata <= {r_wdata[23:0], r_rx_shift};
          r_cnt   <= r_cnt + 2'd1;
        end
        C_BUS_RD: r_rd_shift <= rdata;
        C_SEND: begin
          if (w_tx_load) r_rd_shift <= {r_rd_shift[23:0], 8'h00};
          if (w_tx_done) r_cnt <= r_cnt + 2'd1;
        end
        default: begin
        end
      endcase
    end
  end

  // Transmitter: start bit driven on load, then 8 data bits LSB first and the stop bit.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_tx        <= 1'b1;
      r_tx_active <= 1'b0;
      r_tx_cnt    <= 16'd0;
      r_tx_bit    <= 4'd0;
      r_tx_shift  <= 9'd0;
    end else if (w_tx_load) begin
      r_tx        <= 1'b0;
      r_tx_active <= 1'b1;
      r_tx_cnt    <= 16'd0;
      r_tx_bit    <= 4'd0;
      r_tx_shift  <= {1'b1, r_rd_shift[31:24]};
    end else if (r_tx_active) begin
      if (w_tx_tick) begin
        r_tx_cnt <= 16'd0;
        if (r_tx_bit == 4'd9) begin
          r_tx_active <= 1'b0;
          r_tx        <= 1'b1;
        end else begin
          r_tx       <= r_tx_shift[0];
          r_tx_shift <= {1'b1, r_tx_shift[8:1]};
          r_tx_bit   <= r_tx_bit + 4'd1;
        end
      end else begin
        r_tx_cnt <= r_tx_cnt + 16'd1;
      end
    end
  end

  assign uart_tx   = r_tx;
  assign rd        = r_rd;
  assign wr        = r_wr;
  assign addr      = r_addr;
  assign wdata     = r_wdata;
  assign busy      = r_busy;
  assign frame_err = r_frame_err;
endmodule

// File: tb/tb_uart_bus_bridge.sv
// Bench for uart_bus_bridge at BAUD_DIV=16: scoreboarded bus writes and UART read
// responses, plus ignored opcode, frame error, start glitch and mid-response reset.
module tb_uart_bus_bridge;
  localparam int BD = 16;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        uart_rx = 1'b1;
  logic        uart_tx, rd, wr, busy, frame_err;
  logic [31:0] addr, wdata, rdata;

  int n_vec = 0;
  int n_err = 0;
  int wr_count = 0;
  int rd_count = 0;
  int fe_count = 0;
  int tx_done_count = 0;
  logic [63:0] wr_q[$];
  logic [7:0]  tx_q[$];
  logic [63:0] wr_exp;
  logic [7:0]  mon_exp;
  logic        mon_bit;
  logic        mon_abort;

  uart_bus_bridge #(.BAUD_DIV(BD)) dut (
    .clk(clk), .reset(reset), .uart_rx(uart_rx), .uart_tx(uart_tx),
    .rd(rd), .wr(wr), .addr(addr), .wdata(wdata), .rdata(rdata),
    .busy(busy), .frame_err(frame_err)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] mem_model(input logic [31:0] a);
    case (a)
      32'h4000_0010: mem_model = 32'h0000_005A;
      32'h0000_0020: mem_model = 32'hC3A5_1E87;
      default:       mem_model = 32'hFFFF_FFFF;
    endcase
  endfunction

  assign rdata = mem_model(addr);

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Bus strobe monitor: pops the write scoreboard on every wr cycle.
  always @(negedge clk) begin
    if (reset && (rd || wr)) check("rd_wr_exclusive", {31'd0, rd & wr}, 32'd0);
    if (reset && wr) begin
      wr_count++;
      if (wr_q.size() == 0) begin
        check("wr_unexpected", {31'd0, wr}, 32'd0);
      end else begin
        wr_exp = wr_q.pop_front();
        check("wr_addr", addr, wr_exp[63:32]);
        check("wr_data", wdata, wr_exp[31:0]);
      end
    end
    if (reset && rd) rd_count++;
    if (reset && frame_err) fe_count++;
  end

  // UART response monitor: checks every bit near both ends of its BD-cycle window.
  always begin
    @(negedge clk);
    if (reset && (uart_tx === 1'b0)) begin
      if (tx_q.size() == 0) begin
        check("tx_unexpected", {31'd0, uart_tx}, 32'd1);
      end else begin
        mon_exp   = tx_q.pop_front();
        mon_abort = 1'b0;
        for (int i = 1; i < 10 * BD; i++) begin
          @(negedge clk);
          if (!reset) begin
            mon_abort = 1'b1;
            break;
          end
          if (((i % BD) == 1) || ((i % BD) == (BD - 2))) begin
            mon_bit = (i / BD == 0) ? 1'b0 : (i / BD == 9) ? 1'b1 : mon_exp[i / BD - 1];
            check($sformatf("tx_bit%0d_of_%h", i / BD, mon_exp), {31'd0, uart_tx}, {31'd0, mon_bit});
          end
        end
        if (!mon_abort) tx_done_count++;
      end
    end
  end

  task automatic send_byte(input logic [7:0] b, input logic stop);
    uart_rx = 1'b0;
    repeat (BD) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      uart_rx = b[i];
      repeat (BD) @(negedge clk);
    end
    uart_rx = stop;
    repeat (BD) @(negedge clk);
    uart_rx = 1'b1;
    repeat (4) @(negedge clk);
  endtask

  task automatic send_word(input logic [31:0] w);
    for (int i = 3; i >= 0; i--) send_byte(w[8*i +: 8], 1'b1);
  endtask

  task automatic wait_cnt(input string tag, input int which, input int target, input int budget);
    int c;
    for (int i = 0; i < budget; i++) begin
      c = (which == 0) ? wr_count : tx_done_count;
      if (c >= target) break;
      @(negedge clk);
    end
    c = (which == 0) ? wr_count : tx_done_count;
    check(tag, 32'(c), 32'(target));
  endtask

  task automatic do_write(input logic [31:0] a, input logic [31:0] d);
    int wr0, rd0;
    wr0 = wr_count;
    rd0 = rd_count;
    wr_q.push_back({a, d});
    send_byte(8'h57, 1'b1);
    check("wr_busy_after_op", {31'd0, busy}, 32'd1);
    send_word(a);
    send_word(d);
    wait_cnt("wr_strobe_seen", 0, wr0 + 1, 200);
    repeat (2) @(negedge clk);
    check("wr_single_strobe", 32'(wr_count - wr0), 32'd1);
    check("wr_no_rd", 32'(rd_count - rd0), 32'd0);
    check("wr_busy_done", {31'd0, busy}, 32'd0);
    repeat (40) @(negedge clk);
    check("wr_addr_held", addr, a);
    check("wr_data_held", wdata, d);
  endtask

  task automatic do_read(input logic [31:0] a);
    int rd0, wr0, t0;
    logic [31:0] ew;
    rd0 = rd_count;
    wr0 = wr_count;
    t0  = tx_done_count;
    ew  = mem_model(a);
    for (int i = 3; i >= 0; i--) tx_q.push_back(ew[8*i +: 8]);
    send_byte(8'h52, 1'b1);
    check("rd_busy_after_op", {31'd0, busy}, 32'd1);
    send_word(a);
    wait_cnt("rd_resp_bytes", 1, t0 + 4, 4 * 10 * BD + 200);
    repeat (4) @(negedge clk);
    check("rd_single_strobe", 32'(rd_count - rd0), 32'd1);
    check("rd_no_wr", 32'(wr_count - wr0), 32'd0);
    check("rd_busy_done", {31'd0, busy}, 32'd0);
    check("rd_tx_idle", {31'd0, uart_tx}, 32'd1);
    check("rd_addr_held", addr, a);
  endtask

  initial begin
    int wr0, fe0, t0;
    logic [31:0] ew;

    repeat (3) @(negedge clk);
    check("rst_uart_tx", {31'd0, uart_tx}, 32'd1);
    check("rst_rd", {31'd0, rd}, 32'd0);
    check("rst_wr", {31'd0, wr}, 32'd0);
    check("rst_addr", addr, 32'd0);
    check("rst_wdata", wdata, 32'd0);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_frame_err", {31'd0, frame_err}, 32'd0);
    reset = 1'b1;
    repeat (5) @(negedge clk);

    do_write(32'h4000_000C, 32'h0000_00A5);
    do_read(32'h4000_0010);
    do_read(32'h0000_0020);

    // Unknown opcode is ignored, following write still works.
    wr0 = wr_count;
    send_byte(8'h33, 1'b1);
    check("ign_busy", {31'd0, busy}, 32'd0);
    check("ign_no_wr", 32'(wr_count - wr0), 32'd0);
    do_write(32'h0000_0100, 32'hDEAD_BEEF);

    // Stop-bit error aborts the frame.
    wr0 = wr_count;
    fe0 = fe_count;
    send_byte(8'h57, 1'b1);
    send_byte(8'h40, 1'b0);
    repeat (4) @(negedge clk);
    check("fe_pulse_once", 32'(fe_count - fe0), 32'd1);
    check("fe_busy_low", {31'd0, busy}, 32'd0);
    check("fe_no_wr", 32'(wr_count - wr0), 32'd0);
    do_write(32'h1234_5678, 32'h9ABC_DEF0);

    // Short low glitch is not a start bit.
    fe0 = fe_count;
    uart_rx = 1'b0;
    repeat (4) @(negedge clk);
    uart_rx = 1'b1;
    repeat (40) @(negedge clk);
    check("glitch_busy", {31'd0, busy}, 32'd0);
    check("glitch_no_fe", 32'(fe_count - fe0), 32'd0);
    do_write(32'hFFFF_FFF0, 32'h0000_0001);

    // Reset during the second response byte.
    t0 = tx_done_count;
    ew = mem_model(32'h0000_0020);
    for (int i = 3; i >= 0; i--) tx_q.push_back(ew[8*i +: 8]);
    send_byte(8'h52, 1'b1);
    send_word(32'h0000_0020);
    wait_cnt("rst_first_byte", 1, t0 + 1, 20 * BD);
    repeat (3 * BD) @(negedge clk);
    #2 reset = 1'b0;
    #1;
    check("rst_mid_uart_tx", {31'd0, uart_tx}, 32'd1);
    check("rst_mid_rd", {31'd0, rd}, 32'd0);
    check("rst_mid_wr", {31'd0, wr}, 32'd0);
    check("rst_mid_addr", addr, 32'd0);
    check("rst_mid_wdata", wdata, 32'd0);
    check("rst_mid_busy", {31'd0, busy}, 32'd0);
    tx_q.delete();
    repeat (5) @(negedge clk);
    check("rst_mid_tx_aborted", 32'(tx_done_count), 32'(t0 + 1));
    reset = 1'b1;
    repeat (5) @(negedge clk);
    do_write(32'h8000_0004, 32'h0BAD_F00D);
    check("total_fe_pulses", 32'(fe_count), 32'd1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
